// File: rtl/audio_peak_meter_core.sv
// Multi-channel PCM level meter: per-channel bar with hold/decay ballistics, a since-clear
// peak level and a sticky clip flag, plus a registered random-access read port.
module audio_peak_meter_core #(
    parameter int  CHANNELS      = 2,
    parameter int  AUDIO_WIDTH   = 16,
    parameter int  HOLD_SAMPLES  = 4410,
    parameter int  DECAY_SAMPLES = 441,
    localparam int LW            = $clog2(AUDIO_WIDTH),
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [CW-1:0]          i_channel,
    input  logic [AUDIO_WIDTH-1:0] i_audio,
    input  logic                   i_clear_peak,
    input  logic [CW-1:0]          i_rd_channel,
    output logic [LW-1:0]          o_rd_bar,
    output logic [LW-1:0]          o_rd_peak,
    output logic                   o_rd_clip,
    output logic                   o_update,
    output logic [CW-1:0]          o_update_channel
);

    localparam int HW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam int DW = (DECAY_SAMPLES > 0) ? $clog2(DECAY_SAMPLES + 1) : 1;
    localparam logic [AUDIO_WIDTH-1:0] MIN_S = {1'b1, {(AUDIO_WIDTH-1){1'b0}}};
    localparam logic [AUDIO_WIDTH-1:0] MAX_S = {1'b0, {(AUDIO_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_READ, S_UPDATE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic [AUDIO_WIDTH-1:0] x_q, x_d;

    logic [LW-1:0] bar_q   [CHANNELS];
    logic [LW-1:0] bar_d   [CHANNELS];
    logic [LW-1:0] peak_q  [CHANNELS];
    logic [LW-1:0] peak_d  [CHANNELS];
    logic [HW-1:0] hold_q  [CHANNELS];
    logic [HW-1:0] hold_d  [CHANNELS];
    logic [DW-1:0] decay_q [CHANNELS];
    logic [DW-1:0] decay_d [CHANNELS];
    logic          clip_q  [CHANNELS];
    logic          clip_d  [CHANNELS];

    logic [AUDIO_WIDTH-1:0] mag;
    logic [LW-1:0]          lvl, lvl_q;
    logic                   hit, hit_q;
    logic [LW-1:0]          sel_bar, f_bar_q, nb;
    logic [HW-1:0]          sel_hold, f_hold_q, nh;
    logic [DW-1:0]          sel_decay, f_decay_q, nd;
    logic                   sel_hit, upd;
    logic [LW-1:0]          rd_bar_d, rd_peak_d;
    logic                   rd_clip_d;

    assign i_ready = (state_q == S_IDLE) && !reset;
    assign upd     = (state_q == S_UPDATE) && sel_hit;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        x_d     = x_q;
        case (state_q)
            S_IDLE: if (i_valid) begin
                state_d = S_READ;
                ch_d    = i_channel;
                x_d     = i_audio;
            end
            S_READ:   state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Saturating magnitude and its bit length.
    always_comb begin
        mag = x_q[AUDIO_WIDTH-1] ? -x_q : x_q;
        if (x_q == MIN_S) mag = MAX_S;
        lvl = '0;
        for (int i = 0; i < AUDIO_WIDTH; i++) begin
            if (mag[i]) lvl = LW'(i + 1);
        end
        hit = (x_q == MAX_S) || (x_q == MIN_S);
    end

    always_comb begin
        sel_bar   = '0;
        sel_hold  = '0;
        sel_decay = '0;
        sel_hit   = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == CW'(c)) begin
                sel_bar   = bar_q[c];
                sel_hold  = hold_q[c];
                sel_decay = decay_q[c];
                sel_hit   = 1'b1;
            end
        end
    end

    always_comb begin
        nb = f_bar_q;
        nh = f_hold_q;
        nd = f_decay_q;
        if (lvl_q >= f_bar_q) begin
            nb = lvl_q;
            nh = HW'(HOLD_SAMPLES);
            nd = DW'(DECAY_SAMPLES);
        end else if (f_hold_q != '0) begin
            nh = f_hold_q - 1'b1;
        end else if (f_decay_q > DW'(1)) begin
            nd = f_decay_q - 1'b1;
        end else begin
            if (f_bar_q != '0) nb = f_bar_q - 1'b1;
            nd = DW'(DECAY_SAMPLES);
        end
    end

    // Peak/clip merge with the live values so a clear landing during READ is not undone.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            bar_d[c]   = bar_q[c];
            hold_d[c]  = hold_q[c];
            decay_d[c] = decay_q[c];
            peak_d[c]  = peak_q[c];
            clip_d[c]  = clip_q[c];
            if (state_q == S_UPDATE && ch_q == CW'(c)) begin
                bar_d[c]   = nb;
                hold_d[c]  = nh;
                decay_d[c] = nd;
                peak_d[c]  = (lvl_q > peak_q[c]) ? lvl_q : peak_q[c];
                clip_d[c]  = clip_q[c] | hit_q;
            end
            if (i_clear_peak) begin
                peak_d[c] = '0;
                clip_d[c] = 1'b0;
            end
        end
    end

    always_comb begin
        rd_bar_d  = '0;
        rd_peak_d = '0;
        rd_clip_d = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (i_rd_channel == CW'(c)) begin
                rd_bar_d  = bar_d[c];
                rd_peak_d = peak_d[c];
                rd_clip_d = clip_d[c];
            end
        end
    end

    // NOTE: channel storage is plain flops, so it is reset along with the control state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            ch_q             <= '0;
            x_q              <= '0;
            lvl_q            <= '0;
            hit_q            <= 1'b0;
            f_bar_q          <= '0;
            f_hold_q         <= '0;
            f_decay_q        <= '0;
            o_rd_bar         <= '0;
            o_rd_peak        <= '0;
            o_rd_clip        <= 1'b0;
            o_update         <= 1'b0;
            o_update_channel <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                bar_q[c]   <= '0;
                hold_q[c]  <= '0;
                decay_q[c] <= '0;
                peak_q[c]  <= '0;
                clip_q[c]  <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            x_q     <= x_d;
            if (state_q == S_READ) begin
                lvl_q     <= lvl;
                hit_q     <= hit;
                f_bar_q   <= sel_bar;
                f_hold_q  <= sel_hold;
                f_decay_q <= sel_decay;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                bar_q[c]   <= bar_d[c];
                hold_q[c]  <= hold_d[c];
                decay_q[c] <= decay_d[c];
                peak_q[c]  <= peak_d[c];
                clip_q[c]  <= clip_d[c];
            end
            o_rd_bar  <= rd_bar_d;
            o_rd_peak <= rd_peak_d;
            o_rd_clip <= rd_clip_d;
            o_update  <= upd;
            if (upd) o_update_channel <= ch_q;
        end
    end

endmodule

// File: tb/tb_audio_peak_meter_core.sv
// Bench for audio_peak_meter_core: transaction-level model checked every cycle, directed
// scenarios pinned with hand-computed levels, then a randomized stream.
module tb_audio_peak_meter_core;

    localparam int CH    = 3;
    localparam int AW    = 16;
    localparam int HOLD  = 4;
    localparam int DECAY = 2;
    localparam int CW    = 2;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_clear_peak = 1'b0;
    logic [CW-1:0] i_channel = '0;
    logic [CW-1:0] i_rd_channel = '0;
    logic [AW-1:0] i_audio = '0;
    logic          i_ready;
    logic [LW-1:0] o_rd_bar, o_rd_peak;
    logic          o_rd_clip, o_update;
    logic [CW-1:0] o_update_channel;

    audio_peak_meter_core #(
        .CHANNELS(CH), .AUDIO_WIDTH(AW), .HOLD_SAMPLES(HOLD), .DECAY_SAMPLES(DECAY)
    ) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
        .i_channel(i_channel), .i_audio(i_audio), .i_clear_peak(i_clear_peak),
        .i_rd_channel(i_rd_channel), .o_rd_bar(o_rd_bar), .o_rd_peak(o_rd_peak),
        .o_rd_clip(o_rd_clip), .o_update(o_update), .o_update_channel(o_update_channel)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int upd_seen = 0;
    bit chk_en = 1'b0;
    bit rand_mode = 1'b0;

    // Behavioural model: per-channel meter state plus a pending-sample countdown.
    int          m_bar[CH], m_hold[CH], m_decay[CH], m_peak[CH];
    bit          m_clip[CH];
    int          m_busy = 0;
    int          m_ch = 0;
    logic [15:0] m_x = '0;
    bit          m_upd = 1'b0;
    int          m_upd_ch = 0;
    int          e_bar = 0, e_peak = 0;
    bit          e_clip = 1'b0;

    function automatic int level(input logic [15:0] x);
        int v;
        int mag;
        int l;
        v = int'($signed(x));
        mag = (v < 0) ? -v : v;
        if (mag > 32767) mag = 32767;
        l = 0;
        while (mag > 0) begin
            l++;
            mag = mag / 2;
        end
        return l;
    endfunction

    task automatic m_apply(input int c, input logic [15:0] x);
        int l;
        l = level(x);
        if (l >= m_bar[c]) begin
            m_bar[c] = l;
            m_hold[c] = HOLD;
            m_decay[c] = DECAY;
        end else if (m_hold[c] != 0) begin
            m_hold[c]--;
        end else if (m_decay[c] > 1) begin
            m_decay[c]--;
        end else begin
            if (m_bar[c] > 0) m_bar[c]--;
            m_decay[c] = DECAY;
        end
        if (l > m_peak[c]) m_peak[c] = l;
        if (x == 16'h7fff || x == 16'h8000) m_clip[c] = 1'b1;
    endtask

    always @(posedge clk) begin
        int rc;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_bar[c] = 0; m_hold[c] = 0; m_decay[c] = 0; m_peak[c] = 0; m_clip[c] = 1'b0;
            end
            m_busy = 0; m_upd = 1'b0; m_upd_ch = 0;
            e_bar = 0; e_peak = 0; e_clip = 1'b0;
        end else begin
            m_upd = 1'b0;
            if (m_busy == 1) begin
                if (m_ch < CH) begin
                    m_apply(m_ch, m_x);
                    m_upd = 1'b1;
                    m_upd_ch = m_ch;
                end
                m_busy = 0;
            end else if (m_busy == 2) begin
                m_busy = 1;
            end else if (i_valid) begin
                m_busy = 2;
                m_ch = int'(i_channel);
                m_x = i_audio;
            end
            if (i_clear_peak) begin
                for (int c = 0; c < CH; c++) begin
                    m_peak[c] = 0;
                    m_clip[c] = 1'b0;
                end
            end
            rc = int'(i_rd_channel);
            if (rc < CH) begin
                e_bar = m_bar[rc]; e_peak = m_peak[rc]; e_clip = m_clip[rc];
            end else begin
                e_bar = 0; e_peak = 0; e_clip = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", i_ready, !reset && m_busy == 0);
            check("update", o_update, m_upd);
            if (m_upd) check("update_channel", o_update_channel, m_upd_ch);
            check("rd_bar", o_rd_bar, e_bar);
            check("rd_peak", o_rd_peak, e_peak);
            check("rd_clip", o_rd_clip, e_clip);
            if (o_update === 1'b1) upd_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            i_rd_channel = CW'($urandom_range(0, 3));
            i_clear_peak = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    // Offer a sample, hold it until accepted; returns one cycle after the transfer edge.
    task automatic send(input int ch, input logic [15:0] x);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_channel = CW'(ch);
        i_audio = x;
        while (!i_ready && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) check("send_ready_timeout", i_ready, 1);
        tick();
        i_valid = 1'b0;
        i_audio = 16'($urandom);
    endtask

    task automatic peek(input int ch, input int eb, input int ep, input int ec, input string name);
        i_rd_channel = CW'(ch);
        tick();
        tick();
        check({name, "_bar"}, o_rd_bar, eb);
        check({name, "_peak"}, o_rd_peak, ep);
        check({name, "_clip"}, o_rd_clip, ec);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        logic [15:0] x;
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset_ready", i_ready, 0);
        reset = 1'b0;
        #1;
        check("post_reset_ready", i_ready, 1);
        check("reset_rd_bar", o_rd_bar, 0);
        check("reset_rd_peak", o_rd_peak, 0);
        check("reset_rd_clip", o_rd_clip, 0);
        check("reset_update", o_update, 0);
        check("reset_update_channel", o_update_channel, 0);

        // Stereo stream with back-to-back valid.
        base = upd_seen;
        send(0, 16'h0123);
        send(1, 16'h4567);
        send(0, 16'h89ab);
        send(1, 16'hcdef);
        settle();
        check("stream_update_count", upd_seen - base, 4);
        peek(0, 15, 15, 0, "stream_ch0");
        peek(1, 15, 15, 0, "stream_ch1");

        // Hold then decay on ch0.
        send(0, 16'h4000);
        settle();
        for (int k = 1; k <= 40; k++) begin
            send(0, 16'h0000);
            settle();
            if (k == 5)  peek(0, 15, 15, 0, "hold_z5");
            if (k == 6)  peek(0, 14, 15, 0, "decay_z6");
            if (k == 7)  peek(0, 14, 15, 0, "decay_z7");
            if (k == 8)  peek(0, 13, 15, 0, "decay_z8");
            if (k == 33) peek(0, 1, 15, 0, "decay_z33");
            if (k == 34) peek(0, 0, 15, 0, "decay_z34");
            if (k == 40) peek(0, 0, 15, 0, "decay_z40");
        end

        // Clip detection at both rails, and -1 with no clip.
        send(1, 16'h8000);
        settle();
        peek(1, 15, 15, 1, "clip_neg");
        i_clear_peak = 1'b1;
        tick();
        i_clear_peak = 1'b0;
        settle();
        peek(1, 15, 0, 0, "cleared_ch1");
        send(1, 16'h7fff);
        settle();
        peek(1, 15, 15, 1, "clip_pos");
        send(2, 16'hffff);
        settle();
        peek(2, 1, 1, 0, "minus_one");

        // Clear coinciding with the write-back edge.
        send(0, 16'h7fff);
        tick();
        i_clear_peak = 1'b1;
        tick();
        i_clear_peak = 1'b0;
        settle();
        peek(0, 15, 0, 0, "clear_wins_ch0");
        peek(1, 15, 0, 0, "clear_wins_ch1");

        // Out-of-range channel: accepted, nothing written.
        base = upd_seen;
        send(3, 16'h7fff);
        settle();
        check("oor_no_update", upd_seen - base, 0);
        peek(2, 1, 0, 0, "oor_ch2");

        // Reset during READ aborts the sample.
        send(1, 16'h7fff);
        reset = 1'b1;
        #1;
        check("mid_reset_ready", i_ready, 0);
        base = upd_seen;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("mid_reset_ready_back", i_ready, 1);
        settle();
        check("mid_reset_no_update", upd_seen - base, 0);
        peek(1, 0, 0, 0, "mid_reset_ch1");
        peek(0, 0, 0, 0, "mid_reset_ch0");

        // Randomized stream against the model.
        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0:       x = 16'h0000;
                1:       x = 16'h7fff;
                2:       x = 16'h8000;
                3:       x = 16'($urandom_range(0, 255));
                default: x = 16'($urandom);
            endcase
            send($urandom_range(0, 3), x);
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_mode = 1'b0;
        i_clear_peak = 1'b0;
        settle();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
